imem_loader: RTL

- Byte-stream program loader: the write side of the byte-addressed, little-endian instruction memory that the single-cycle datapath reads by PC.
- Accepts a framed byte stream over a valid/ready handshake and checks the frame's XOR checksum.
- Issues one byte write per accepted data byte into the memory's write port, then releases the core via cpu_hold.

---
 rtl/imem_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader
// Write side of the byte-addressed, little-endian instruction memory. A framed
// byte stream (len_lo, len_hi, 4*N data bytes, XOR checksum) arrives over a
// valid/ready handshake. Each data byte becomes one memory byte write. The core
// is released through cpu_hold once the checksum matches.
//
// Handshake: a byte moves on a rising clk edge where in_valid && in_ready. The
// source holds in_data stable while in_valid is high and unaccepted. in_valid
// low is a gap and changes nothing. in_ready is registered.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             one-cycle pulse that begins a load (IDLE/DONE/ERR only)
//   in_valid/in_data  stream byte offered by the source
//   in_ready          loader accepts a byte this cycle
//   mem_we/mem_addr/mem_wdata  byte write port, one cycle after each data accept
//   cpu_hold          holds the core while high
//   done / err        level outputs: good load / aborted load
//   words_loaded      complete 4-byte words written in the current load
//   (the FSM state is visible as the internal signal 'state')
module imem_loader #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [15:0] count;
  logic [17:0] byte_idx;
  logic [7:0]  csum;

  logic        accept;
  logic [15:0] len_full;
  logic [17:0] byte_idx_inc;
  logic        last_byte;
  logic        idle_like;

  assign accept       = in_valid && in_ready;
  assign len_full     = {in_data, count[7:0]};
  assign byte_idx_inc = byte_idx + 18'd1;
  // count is at most MAX_WORDS here, so 4*count fits in the 18-bit index.
  assign last_byte    = (byte_idx_inc == {count, 2'b00});
  assign idle_like    = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_next = S_LEN_LO;
      S_LEN_LO: if (accept) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_full} > MAX_W) state_next = S_ERR;
          else if (len_full == 16'd0)   state_next = S_CSUM;
          else                          state_next = S_DATA;
        end
      end
      S_DATA: if (accept && last_byte) state_next = S_CSUM;
      S_CSUM: begin
        if (accept) state_next = (in_data == csum) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= 16'd0;
      byte_idx     <= 18'd0;
      csum         <= 8'd0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 64'd0;
      mem_wdata    <= 8'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= 16'd0;
    end else begin
      state  <= state_next;
      mem_we <= 1'b0;
      // Registered ready tracks the state being entered, so it is valid in
      // the same cycle the FSM arrives in a receiving state.
      in_ready <= (state_next == S_LEN_LO) || (state_next == S_LEN_HI) ||
                  (state_next == S_DATA)   || (state_next == S_CSUM);

      if (idle_like && start) begin
        done         <= 1'b0;
        err          <= 1'b0;
        words_loaded <= 16'd0;
        byte_idx     <= 18'd0;
        csum         <= 8'd0;
        cpu_hold     <= 1'b1;
      end

      if (accept) begin
        case (state)
          S_LEN_LO: count[7:0]  <= in_data;
          S_LEN_HI: begin
            count[15:8] <= in_data;
            if ({1'b0, len_full} > MAX_W) err <= 1'b1;
          end
          S_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + {46'd0, byte_idx};
            mem_wdata <= in_data;
            byte_idx  <= byte_idx_inc;
            csum      <= csum ^ in_data;
            if (byte_idx[1:0] == 2'b11) words_loaded <= words_loaded + 16'd1;
          end
          S_CSUM: begin
            if (in_data == csum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
